// File: rtl/llsc_mem_arbiter_pkg.sv
// Shared command and FSM encodings for the LL/SC data-RAM arbiter.
package llsc_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        CMD_RD = 2'd0,
        CMD_WR = 2'd1,
        CMD_LL = 2'd2,
        CMD_SC = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    function automatic logic cmd_reads(input cmd_e c);
        return (c == CMD_RD) || (c == CMD_LL);
    endfunction

endpackage

// File: rtl/llsc_mem_arbiter_if.sv
// One requester port of the arbiter: request bundle plus completion response.
interface llsc_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import llsc_mem_arbiter_pkg::*;

    logic                req;
    cmd_e                cmd;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W/8-1:0] sel;
    logic [DATA_W-1:0]   wdata;
    logic                llclr;
    logic                ack;
    logic [DATA_W-1:0]   rdata;
    logic                sc_ok;

    modport master (
        output req, cmd, addr, sel, wdata, llclr,
        input  ack, rdata, sc_ok
    );

    modport slave (
        input  req, cmd, addr, sel, wdata, llclr,
        output ack, rdata, sc_ok
    );

endinterface

// File: rtl/llsc_resv.sv
// Single LL/SC reservation: an LL set wins over every clearing source on the same edge.
module llsc_resv #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic [ADDR_W-3:0] set_addr,
    input  logic              clr_own,
    input  logic              snoop_we,
    input  logic [ADDR_W-3:0] snoop_addr,
    input  logic              llclr,
    output logic              valid,
    output logic [ADDR_W-3:0] resv_addr
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid     <= 1'b0;
            resv_addr <= '0;
        end else if (set) begin
            valid     <= 1'b1;
            resv_addr <= set_addr;
        end else if (clr_own || llclr || (snoop_we && (snoop_addr == resv_addr))) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/llsc_mem_arbiter.sv
// Two-master arbiter for the byte-banked data RAM with per-master LL/SC reservations.
module llsc_mem_arbiter
    import llsc_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int FAIR   = 1
) (
    input  logic                clk,
    input  logic                rst,
    llsc_mem_arbiter_if.slave   m0,
    llsc_mem_arbiter_if.slave   m1,
    output logic                ram_ce,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W/8-1:0] ram_sel,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    state_e              state, state_nx;
    logic                gnt;     // 0 = m0, 1 = m1
    logic                prio;    // master favoured when both request
    logic                win;
    cmd_e                cmd_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W/8-1:0] sel_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                sc_ok_r;
    logic                sc_pass;
    logic                resv_v0, resv_v1;
    logic [ADDR_W-3:0]   resv_a0, resv_a1;
    logic [ADDR_W-3:0]   word_r;

    assign word_r  = addr_r[ADDR_W-1:2];
    assign sc_pass = gnt ? (resv_v1 && (resv_a1 == word_r))
                         : (resv_v0 && (resv_a0 == word_r));

    always_comb begin
        win = 1'b0;
        if (m0.req && m1.req)
            win = (FAIR != 0) ? prio : 1'b0;
        else if (m1.req)
            win = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:   if (m0.req || m1.req) state_nx = ST_ACCESS;
            ST_ACCESS: state_nx = ST_RESP;
            ST_RESP:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt     <= 1'b0;
            prio    <= 1'b0;
            cmd_r   <= CMD_RD;
            addr_r  <= '0;
            sel_r   <= '0;
            wdata_r <= '0;
            sc_ok_r <= 1'b0;
        end else begin
            if (state == ST_IDLE && (m0.req || m1.req)) begin
                gnt     <= win;
                prio    <= ~win;
                cmd_r   <= win ? m1.cmd   : m0.cmd;
                addr_r  <= win ? m1.addr  : m0.addr;
                sel_r   <= win ? m1.sel   : m0.sel;
                wdata_r <= win ? m1.wdata : m0.wdata;
            end
            if (state == ST_ACCESS)
                sc_ok_r <= (cmd_r == CMD_SC) && sc_pass;
        end
    end

    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_sel   = '0;
        ram_wdata = '0;
        m0.ack    = 1'b0;
        m0.rdata  = '0;
        m0.sc_ok  = 1'b0;
        m1.ack    = 1'b0;
        m1.rdata  = '0;
        m1.sc_ok  = 1'b0;
        unique case (state)
            ST_ACCESS: begin
                ram_addr  = addr_r;
                ram_sel   = sel_r;
                ram_wdata = wdata_r;
                unique case (cmd_r)
                    CMD_RD, CMD_LL: ram_ce = 1'b1;
                    CMD_WR: begin
                        ram_ce = 1'b1;
                        ram_we = 1'b1;
                    end
                    CMD_SC: begin
                        ram_ce = sc_pass;
                        ram_we = sc_pass;
                    end
                    default: ;
                endcase
            end
            ST_RESP: begin
                if (gnt) begin
                    m1.ack   = 1'b1;
                    m1.rdata = cmd_reads(cmd_r) ? ram_rdata : '0;
                    m1.sc_ok = (cmd_r == CMD_SC) && sc_ok_r;
                end else begin
                    m0.ack   = 1'b1;
                    m0.rdata = cmd_reads(cmd_r) ? ram_rdata : '0;
                    m0.sc_ok = (cmd_r == CMD_SC) && sc_ok_r;
                end
            end
            default: ;
        endcase
    end

    // Reservations snoop ram_we so that only writes that reach memory clear them.
    llsc_resv #(.ADDR_W(ADDR_W)) u_resv0 (
        .clk       (clk),
        .rst       (rst),
        .set       (state == ST_ACCESS && !gnt && cmd_r == CMD_LL),
        .set_addr  (word_r),
        .clr_own   (state == ST_ACCESS && !gnt && cmd_r == CMD_SC),
        .snoop_we  (ram_we),
        .snoop_addr(word_r),
        .llclr     (m0.llclr),
        .valid     (resv_v0),
        .resv_addr (resv_a0)
    );

    llsc_resv #(.ADDR_W(ADDR_W)) u_resv1 (
        .clk       (clk),
        .rst       (rst),
        .set       (state == ST_ACCESS && gnt && cmd_r == CMD_LL),
        .set_addr  (word_r),
        .clr_own   (state == ST_ACCESS && gnt && cmd_r == CMD_SC),
        .snoop_we  (ram_we),
        .snoop_addr(word_r),
        .llclr     (m1.llclr),
        .valid     (resv_v1),
        .resv_addr (resv_a1)
    );

endmodule

// File: tb/tb_llsc_mem_arbiter.sv
// Self-checking bench: transaction-level memory/reservation model against two arbiter instances.
module tb_llsc_mem_arbiter;
    import llsc_mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    llsc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
    llsc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();
    llsc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) f0_bus ();
    llsc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) f1_bus ();

    logic          ram_ce, ram_we;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_sel;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          f_ce, f_we;
    logic [AW-1:0] f_addr;
    logic [3:0]    f_sel;
    logic [DW-1:0] f_wdata, f_rdata;
    assign f_rdata = '0;

    llsc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FAIR(1)) dut (
        .clk(clk), .rst(rst), .m0(m0_bus), .m1(m1_bus),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    llsc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FAIR(0)) dut_fixed (
        .clk(clk), .rst(rst), .m0(f0_bus), .m1(f1_bus),
        .ram_ce(f_ce), .ram_we(f_we), .ram_addr(f_addr), .ram_sel(f_sel),
        .ram_wdata(f_wdata), .ram_rdata(f_rdata)
    );

    // Synchronous RAM: read data appears the cycle after ram_ce.
    logic [31:0] mem [NW];
    always @(posedge clk) begin
        if (ram_ce) begin
            ram_rdata = mem[ram_addr[5:2]];
            if (ram_we)
                for (int i = 0; i < 4; i++)
                    if (ram_sel[i]) mem[ram_addr[5:2]][8*i +: 8] = ram_wdata[8*i +: 8];
        end
    end

    logic [31:0] ref_mem [NW];
    logic        rv [2];
    int          ra [2];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic ack_of(input int m);
        return (m == 0) ? m0_bus.ack : m1_bus.ack;
    endfunction
    function automatic logic [31:0] rdata_of(input int m);
        return (m == 0) ? m0_bus.rdata : m1_bus.rdata;
    endfunction
    function automatic logic sc_of(input int m);
        return (m == 0) ? m0_bus.sc_ok : m1_bus.sc_ok;
    endfunction

    task automatic drive(input int m, input logic r, input cmd_e c, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (m == 0) begin
            m0_bus.req = r; m0_bus.cmd = c; m0_bus.addr = a; m0_bus.wdata = d; m0_bus.sel = s;
        end else begin
            m1_bus.req = r; m1_bus.cmd = c; m1_bus.addr = a; m1_bus.wdata = d; m1_bus.sel = s;
        end
    endtask

    task automatic set_llclr(input int m, input logic v);
        if (m == 0) m0_bus.llclr = v;
        else        m1_bus.llclr = v;
    endtask

    task automatic model_write(input int w, input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 4; i++)
            if (s[i]) ref_mem[w][8*i +: 8] = d[8*i +: 8];
        for (int k = 0; k < 2; k++)
            if (rv[k] && ra[k] == w) rv[k] = 1'b0;
    endtask

    // Architectural effect of one completed transaction.
    task automatic model_apply(input int m, input cmd_e c, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s,
                               output logic [31:0] e_rd, output logic e_ok,
                               output logic e_ce, output logic e_we);
        int w;
        w = int'(a[5:2]);
        e_rd = '0; e_ok = 1'b0; e_ce = 1'b1; e_we = 1'b0;
        case (c)
            CMD_RD: e_rd = ref_mem[w];
            CMD_LL: begin
                e_rd = ref_mem[w]; rv[m] = 1'b1; ra[m] = w;
            end
            CMD_WR: begin
                model_write(w, d, s); e_we = 1'b1;
            end
            default: begin
                e_ok = rv[m] && (ra[m] == w);
                rv[m] = 1'b0;
                if (e_ok) begin
                    model_write(w, d, s); e_we = 1'b1;
                end else begin
                    e_ce = 1'b0;
                end
            end
        endcase
    endtask

    task automatic do_access(input int m, input cmd_e c, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s, input logic clr_at_access);
        logic [31:0] e_rd;
        logic        e_ok, e_ce, e_we, got;
        int          lat;
        model_apply(m, c, a, d, s, e_rd, e_ok, e_ce, e_we);
        drive(m, 1'b1, c, a, d, s);
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (ack_of(m)) begin
                got = 1'b1; lat = k;
            end
            if (k == 1) begin
                check("ram_ce", ram_ce, e_ce);
                check("ram_we", ram_we, e_we);
                if (e_ce) check("ram_addr", ram_addr, a);
                if (clr_at_access) set_llclr(m, 1'b1);
            end else begin
                set_llclr(m, 1'b0);
            end
        end
        check("ack_seen", got, 1'b1);
        if (got) begin
            check("ack_latency", lat, 2);
            check("rdata", rdata_of(m), e_rd);
            check("sc_ok", sc_of(m), e_ok);
            check("other_ack", ack_of(1 - m), 1'b0);
        end
        drive(m, 1'b0, CMD_RD, '0, '0, '0);
        set_llclr(m, 1'b0);
        @(negedge clk);
    endtask

    task automatic pulse_llclr(input int m);
        set_llclr(m, 1'b1);
        @(negedge clk);
        set_llclr(m, 1'b0);
        rv[m] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] e_rd;
        logic        e_ok, e_ce, e_we;
        logic [31:0] a;

        for (int i = 0; i < NW; i++) mem[i] = $urandom;
        mem[0] = 32'h1234_5678;
        for (int i = 0; i < NW; i++) ref_mem[i] = mem[i];
        rv[0] = 1'b0; rv[1] = 1'b0; ra[0] = 0; ra[1] = 0;
        drive(0, 1'b0, CMD_RD, '0, '0, '0);
        drive(1, 1'b0, CMD_RD, '0, '0, '0);
        set_llclr(0, 1'b0);
        set_llclr(1, 1'b0);
        f0_bus.req = 1'b0; f0_bus.cmd = CMD_RD; f0_bus.addr = '0; f0_bus.wdata = '0;
        f0_bus.sel = '0; f0_bus.llclr = 1'b0;
        f1_bus.req = 1'b0; f1_bus.cmd = CMD_RD; f1_bus.addr = '0; f1_bus.wdata = '0;
        f1_bus.sel = '0; f1_bus.llclr = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ram_ce", ram_ce, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_m0_ack", m0_bus.ack, 1'b0);
        check("rst_m1_ack", m1_bus.ack, 1'b0);
        check("rst_m0_rdata", m0_bus.rdata, 32'h0);
        check("rst_m0_sc_ok", m0_bus.sc_ok, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // LL then matching SC succeeds
        do_access(0, CMD_LL, 32'h0, 32'h0, 4'hF, 1'b0);
        do_access(0, CMD_SC, 32'h0, 32'hAABB_CCDD, 4'hF, 1'b0);
        check("mem0_after_sc", mem[0], 32'hAABB_CCDD);

        // Foreign write to the reserved word kills the SC
        do_access(0, CMD_LL, 32'h4, 32'h0, 4'hF, 1'b0);
        do_access(1, CMD_WR, 32'h4, 32'h1111_1111, 4'hF, 1'b0);
        do_access(0, CMD_SC, 32'h4, 32'h2222_2222, 4'hF, 1'b0);
        check("mem1_after_failed_sc", mem[1], 32'h1111_1111);

        // SC without LL, SC to a different word, then stale SC
        do_access(0, CMD_SC, 32'h8, 32'hDEAD_BEEF, 4'hF, 1'b0);
        check("mem2_untouched", mem[2], ref_mem[2]);
        do_access(0, CMD_LL, 32'h8, 32'h0, 4'hF, 1'b0);
        do_access(0, CMD_SC, 32'h1, 32'h5555_5555, 4'hF, 1'b0);
        do_access(0, CMD_SC, 32'hB, 32'h6666_6666, 4'hF, 1'b0);

        // llclr pulse, then llclr coinciding with the LL set
        do_access(0, CMD_LL, 32'h4, 32'h0, 4'hF, 1'b0);
        pulse_llclr(0);
        do_access(0, CMD_SC, 32'h4, 32'h3333_3333, 4'hF, 1'b0);
        do_access(0, CMD_LL, 32'h10, 32'h0, 4'hF, 1'b1);
        do_access(0, CMD_SC, 32'h12, 32'hCAFE_F00D, 4'h5, 1'b0);
        check("mem4_after_sc", mem[4], ref_mem[4]);

        for (int n = 0; n < 150; n++) begin
            int   m;
            cmd_e c;
            if ($urandom_range(0, 7) == 0) pulse_llclr(int'($urandom_range(0, 1)));
            m = int'($urandom_range(0, 1));
            c = cmd_e'($urandom_range(0, 3));
            a = ($urandom_range(0, 5) << 2) | $urandom_range(0, 3);
            do_access(m, c, a, $urandom, 4'($urandom), 1'b0);
        end

        // Reset during ACCESS of a WR after m1 holds a reservation
        do_access(1, CMD_LL, 32'hC, 32'h0, 4'hF, 1'b0);
        model_apply(0, CMD_WR, 32'h14, 32'h7777_7777, 4'hF, e_rd, e_ok, e_ce, e_we);
        drive(0, 1'b1, CMD_WR, 32'h14, 32'h7777_7777, 4'hF);
        @(negedge clk);
        check("pre_rst_ram_ce", ram_ce, 1'b1);
        rst = 1'b0;
        drive(0, 1'b0, CMD_RD, '0, '0, '0);
        @(negedge clk);
        check("abort_ram_ce", ram_ce, 1'b0);
        check("abort_m0_ack", m0_bus.ack, 1'b0);
        check("abort_m1_ack", m1_bus.ack, 1'b0);
        rv[0] = 1'b0; rv[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Both masters request continuously: round-robin starting at m0
        drive(0, 1'b1, CMD_RD, 32'h0, '0, 4'hF);
        drive(1, 1'b1, CMD_RD, 32'h18, '0, 4'hF);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            check("rr_m0_ack", m0_bus.ack, (k == 2 || k == 8));
            check("rr_m1_ack", m1_bus.ack, (k == 5 || k == 11));
            if (k == 2) check("rr_m0_rdata", m0_bus.rdata, ref_mem[0]);
            if (k == 5) check("rr_m1_rdata", m1_bus.rdata, ref_mem[6]);
        end
        drive(0, 1'b0, CMD_RD, '0, '0, '0);
        drive(1, 1'b0, CMD_RD, '0, '0, '0);
        @(negedge clk);
        do_access(1, CMD_SC, 32'hC, 32'h8888_8888, 4'hF, 1'b0);

        // Fixed priority: m0 wins every time while it holds req
        f0_bus.req = 1'b1;
        f1_bus.req = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            check("fixed_m0_ack", f0_bus.ack, (k == 2 || k == 5 || k == 8 || k == 11));
            check("fixed_m1_ack", f1_bus.ack, 1'b0);
        end
        f0_bus.req = 1'b0;
        f1_bus.req = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NW; i++) check("mem_final", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
